// File: rtl/audio_sample_feeder.sv
// Pops stereo codec samples, mixes them to mono and decimates by DECIM for wave_drawer.
// Define AUDIO_FEEDER_GAIN_EN to add a saturating left-shift gain stage (gain_shift port).
module audio_sample_feeder #(
  parameter int unsigned WIDTH = 24,
  parameter int unsigned DECIM = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             read_ready,
  input  logic [WIDTH-1:0] readdata_left,
  input  logic [WIDTH-1:0] readdata_right,
`ifdef AUDIO_FEEDER_GAIN_EN
  input  logic [2:0]       gain_shift,
`endif
  input  logic             freeze,
  output logic             read,
  output logic [WIDTH-1:0] wave_signal,
  output logic             enable
);

  typedef enum logic [1:0] {StIdle, StRead, StProc} state_e;

  state_e           state_q, state_d;
  logic             read_q, read_d;
  logic             enable_q, enable_d;
  logic [WIDTH-1:0] wave_q, wave_d;
  logic [WIDTH-1:0] left_q, left_d;
  logic [WIDTH-1:0] right_q, right_d;
  logic [7:0]       cnt_q, cnt_d;
  logic [WIDTH:0]   sum;
  logic [WIDTH-1:0] mono;
  logic [WIDTH-1:0] mono_out;
  logic             cnt_hit;

  // One extra bit of headroom makes the sum exact; dropping bit 0 floors toward -inf.
  assign sum  = {left_q[WIDTH-1], left_q} + {right_q[WIDTH-1], right_q};
  assign mono = WIDTH'(sum >> 1);

`ifdef AUDIO_FEEDER_GAIN_EN
  localparam logic signed [WIDTH+7:0] SatMax = {9'b0, {(WIDTH-1){1'b1}}};
  localparam logic signed [WIDTH+7:0] SatMin = {9'h1ff, {(WIDTH-1){1'b0}}};

  logic signed [WIDTH+7:0] gained;

  assign gained = $signed({{8{mono[WIDTH-1]}}, mono}) <<< gain_shift;

  always_comb begin
    mono_out = gained[WIDTH-1:0];
    if (gained > SatMax) begin
      mono_out = SatMax[WIDTH-1:0];
    end else if (gained < SatMin) begin
      mono_out = SatMin[WIDTH-1:0];
    end
  end
`else
  assign mono_out = mono;
`endif

  assign cnt_hit = (cnt_q == 8'(DECIM - 1));

  always_comb begin
    state_d  = state_q;
    read_d   = 1'b0;
    enable_d = 1'b0;
    wave_d   = wave_q;
    left_d   = left_q;
    right_d  = right_q;
    cnt_d    = cnt_q;
    case (state_q)
      StIdle: begin
        if (read_ready) begin
          state_d = StRead;
          read_d  = 1'b1;
        end
      end
      StRead: begin
        left_d  = readdata_left;
        right_d = readdata_right;
        state_d = StProc;
      end
      StProc: begin
        // Counter advances even while frozen so decimation phase is kept.
        cnt_d = cnt_hit ? 8'd0 : cnt_q + 8'd1;
        if (cnt_hit && !freeze) begin
          wave_d   = mono_out;
          enable_d = 1'b1;
        end
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= StIdle;
      read_q   <= 1'b0;
      enable_q <= 1'b0;
      wave_q   <= '0;
      left_q   <= '0;
      right_q  <= '0;
      cnt_q    <= 8'd0;
    end else begin
      state_q  <= state_d;
      read_q   <= read_d;
      enable_q <= enable_d;
      wave_q   <= wave_d;
      left_q   <= left_d;
      right_q  <= right_d;
      cnt_q    <= cnt_d;
    end
  end

  assign read        = read_q;
  assign enable      = enable_q;
  assign wave_signal = wave_q;

endmodule

// File: tb/tb_audio_sample_feeder.sv
// Bench for audio_sample_feeder: DECIM=1 and DECIM=4 instances share stimulus and are
// checked against an arithmetic sample-level model.
module tb_audio_sample_feeder;

  localparam int W = 24;

  logic         clk = 1'b0;
  logic         reset;
  logic         read_ready;
  logic         freeze;
  logic [W-1:0] left, right;
  logic         read1, en1, read4, en4;
  logic [W-1:0] wave1, wave4;
`ifdef AUDIO_FEEDER_GAIN_EN
  logic [2:0]   gain_shift;
`endif

  int gs = 0;
  int errors = 0;
  int checks = 0;

  // Reference model state
  int           n1, n4;
  logic [W-1:0] exp_w1, exp_w4;
  logic         exp_en1, exp_en4;

  always #5 clk = ~clk;

  audio_sample_feeder #(.WIDTH(W), .DECIM(1)) dut1 (
    .clk            (clk),
    .reset          (reset),
    .read_ready     (read_ready),
    .readdata_left  (left),
    .readdata_right (right),
`ifdef AUDIO_FEEDER_GAIN_EN
    .gain_shift     (gain_shift),
`endif
    .freeze         (freeze),
    .read           (read1),
    .wave_signal    (wave1),
    .enable         (en1)
  );

  audio_sample_feeder #(.WIDTH(W), .DECIM(4)) dut4 (
    .clk            (clk),
    .reset          (reset),
    .read_ready     (read_ready),
    .readdata_left  (left),
    .readdata_right (right),
`ifdef AUDIO_FEEDER_GAIN_EN
    .gain_shift     (gain_shift),
`endif
    .freeze         (freeze),
    .read           (read4),
    .wave_signal    (wave4),
    .enable         (en4)
  );

  function automatic logic [W-1:0] ref_mono(input int l, input int r);
    longint m, hi, lo;
    hi = (longint'(1) <<< (W - 1)) - 1;
    lo = -(longint'(1) <<< (W - 1));
    m  = (longint'(l) + longint'(r)) >>> 1;
    m  = m <<< gs;
    if (m > hi) m = hi;
    else if (m < lo) m = lo;
    return m[W-1:0];
  endfunction

  task automatic model_reset();
    n1 = 0; n4 = 0; exp_w1 = '0; exp_w4 = '0; exp_en1 = 1'b0; exp_en4 = 1'b0;
  endtask

  task automatic model_step(input int l, input int r, input bit fr);
    logic [W-1:0] m;
    m = ref_mono(l, r);
    exp_en1 = !fr;
    if (exp_en1) exp_w1 = m;
    n1++;
    exp_en4 = ((n4 % 4) == 3) && !fr;
    if (exp_en4) exp_w4 = m;
    n4++;
  endtask

  task automatic apply_reset();
    read_ready = 1'b0;
    freeze = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b1;
    model_reset();
  endtask

  // Offers one sample and follows it to the cycle where its result is visible.
  task automatic pop_one(input int l, input int r, input bit fr, input bit hold,
                         output int lat, output bit bad,
                         output logic o_en1, output logic o_en4,
                         output logic [W-1:0] o_w1, output logic [W-1:0] o_w4);
    left = l[W-1:0];
    right = r[W-1:0];
    freeze = fr;
`ifdef AUDIO_FEEDER_GAIN_EN
    gain_shift = gs[2:0];
`endif
    read_ready = 1'b1;
    bad = 1'b0;
    lat = 10;
    for (int i = 1; i <= 10; i++) begin
      @(negedge clk);
      if (read1 === 1'b1) begin
        lat = i;
        break;
      end
    end
    if (read4 !== 1'b1 || en1 !== 1'b0 || en4 !== 1'b0) bad = 1'b1;
    if (!hold) read_ready = 1'b0;
    @(negedge clk);
    if (read1 !== 1'b0 || read4 !== 1'b0) bad = 1'b1;
    @(negedge clk);
    if (read1 !== 1'b0 || read4 !== 1'b0) bad = 1'b1;
    o_en1 = en1; o_en4 = en4; o_w1 = wave1; o_w4 = wave4;
  endtask

  task automatic test_reset();
    read_ready = 1'b1;
    freeze = 1'b0;
    left = 24'd5;
    right = 24'd7;
    reset = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checks++;
      if ({read1, en1, wave1, read4, en4, wave4} !== '0) begin
        errors++;
        $display("FAIL reset_hold cycle %0d: read=%b/%b en=%b/%b wave=%0d/%0d want all 0",
                 i, read1, read4, en1, en4, wave1, wave4);
      end
    end
    read_ready = 1'b0;
    reset = 1'b1;
    model_reset();
  endtask

  task automatic test_basic();
    int lat; bit bad; logic e1, e4; logic [W-1:0] w1, w4;
    pop_one(100, 200, 1'b0, 1'b0, lat, bad, e1, e4, w1, w4);
    model_step(100, 200, 1'b0);
    checks++;
    if (lat !== 1) begin
      errors++; $display("FAIL basic latency: got %0d want 1", lat);
    end
    checks++;
    if (bad) begin
      errors++; $display("FAIL basic pacing: got bad=1 want 0");
    end
    checks++;
    if (e1 !== 1'b1 || w1 !== 24'd150) begin
      errors++; $display("FAIL basic dut1: got en=%b wave=%0d want en=1 wave=150", e1, w1);
    end
    checks++;
    if (e4 !== exp_en4 || w4 !== exp_w4) begin
      errors++;
      $display("FAIL basic dut4: got en=%b wave=%0d want en=%b wave=%0d", e4, w4, exp_en4, exp_w4);
    end
  endtask

  task automatic test_signed_mix();
    int ls[3] = '{-8388608, 8388607, -1};
    int rs[3] = '{-8388608, -8388608, 0};
    int ws[3] = '{-8388608, -1, -1};
    int lat; bit bad; logic e1, e4; logic [W-1:0] w1, w4, want;
    for (int k = 0; k < 3; k++) begin
      pop_one(ls[k], rs[k], 1'b0, 1'b0, lat, bad, e1, e4, w1, w4);
      model_step(ls[k], rs[k], 1'b0);
      want = ws[k][W-1:0];
      checks++;
      if (lat !== 1 || bad) begin
        errors++; $display("FAIL mix%0d timing: got lat=%0d bad=%b want lat=1 bad=0", k, lat, bad);
      end
      checks++;
      if (e1 !== 1'b1 || w1 !== want) begin
        errors++;
        $display("FAIL mix%0d dut1: got en=%b wave=%0d want en=1 wave=%0d",
                 k, e1, $signed(w1), $signed(want));
      end
      checks++;
      if (e4 !== exp_en4 || w4 !== exp_w4) begin
        errors++;
        $display("FAIL mix%0d dut4: got en=%b wave=%0d want en=%b wave=%0d",
                 k, e4, w4, exp_en4, exp_w4);
      end
    end
  endtask

  task automatic test_decimation();
    int lat; bit bad; logic e1, e4; logic [W-1:0] w1, w4;
    int pulses = 0;
    apply_reset();
    for (int i = 1; i <= 8; i++) begin
      pop_one(i, i, 1'b0, 1'b1, lat, bad, e1, e4, w1, w4);
      model_step(i, i, 1'b0);
      if (e4 === 1'b1) pulses++;
      checks++;
      if (lat !== 1 || bad) begin
        errors++; $display("FAIL decim%0d timing: got lat=%0d bad=%b want lat=1 bad=0", i, lat, bad);
      end
      checks++;
      if (e4 !== exp_en4 || w4 !== exp_w4 || e1 !== exp_en1 || w1 !== exp_w1) begin
        errors++;
        $display("FAIL decim%0d out: got en4=%b w4=%0d en1=%b w1=%0d want %b %0d %b %0d",
                 i, e4, w4, e1, w1, exp_en4, exp_w4, exp_en1, exp_w1);
      end
    end
    read_ready = 1'b0;
    checks++;
    if (pulses != 2) begin
      errors++; $display("FAIL decim_pulses: got %0d want 2", pulses);
    end
  endtask

  task automatic test_freeze();
    int lat; bit bad; logic e1, e4; logic [W-1:0] w1, w4;
    bit fr;
    apply_reset();
    for (int i = 1; i <= 9; i++) begin
      fr = (i >= 5 && i <= 8);
      pop_one(i * 10, i * 10 + 2, fr, 1'b0, lat, bad, e1, e4, w1, w4);
      model_step(i * 10, i * 10 + 2, fr);
      checks++;
      if (lat !== 1 || bad) begin
        errors++; $display("FAIL freeze%0d timing: got lat=%0d bad=%b want lat=1 bad=0", i, lat, bad);
      end
      checks++;
      if (e1 !== exp_en1 || w1 !== exp_w1 || e4 !== exp_en4 || w4 !== exp_w4) begin
        errors++;
        $display("FAIL freeze%0d out: got en1=%b w1=%0d en4=%b w4=%0d want %b %0d %b %0d",
                 i, e1, w1, e4, w4, exp_en1, exp_w1, exp_en4, exp_w4);
      end
    end
  endtask

  task automatic test_async_reset();
    int lat; bit bad; logic e1, e4; logic [W-1:0] w1, w4;
    left = 24'd999;
    right = 24'd999;
    freeze = 1'b0;
    read_ready = 1'b1;
    @(negedge clk);
    checks++;
    if (read1 !== 1'b1) begin
      errors++; $display("FAIL arst_pre: got read=%b want 1", read1);
    end
    #1 reset = 1'b0;
    #1;
    checks++;
    if (read1 !== 1'b0 || read4 !== 1'b0 || wave1 !== '0 || wave4 !== '0) begin
      errors++;
      $display("FAIL arst_drop: got read=%b/%b wave=%0d/%0d want 0", read1, read4, wave1, wave4);
    end
    read_ready = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    model_reset();
    for (int i = 1; i <= 4; i++) begin
      pop_one(50 + i, 50 + i, 1'b0, 1'b0, lat, bad, e1, e4, w1, w4);
      model_step(50 + i, 50 + i, 1'b0);
      checks++;
      if (lat !== 1 || bad || e4 !== exp_en4 || w4 !== exp_w4) begin
        errors++;
        $display("FAIL arst%0d: got lat=%0d bad=%b en4=%b w4=%0d want 1 0 %b %0d",
                 i, lat, bad, e4, w4, exp_en4, exp_w4);
      end
    end
  endtask

  task automatic test_random();
    int lat; bit bad; logic e1, e4; logic [W-1:0] w1, w4;
    int l, r; bit fr, hold;
    for (int i = 0; i < 40; i++) begin
      l = int'($urandom) >>> 8;
      r = int'($urandom) >>> 8;
      fr = ($urandom_range(0, 3) == 0);
      hold = 1'($urandom_range(0, 1));
`ifdef AUDIO_FEEDER_GAIN_EN
      gs = int'($urandom_range(0, 7));
`endif
      pop_one(l, r, fr, hold, lat, bad, e1, e4, w1, w4);
      model_step(l, r, fr);
      checks++;
      if (lat !== 1 || bad) begin
        errors++; $display("FAIL rand%0d timing: got lat=%0d bad=%b want lat=1 bad=0", i, lat, bad);
      end
      checks++;
      if (e1 !== exp_en1 || w1 !== exp_w1 || e4 !== exp_en4 || w4 !== exp_w4) begin
        errors++;
        $display("FAIL rand%0d out: got en1=%b w1=%h en4=%b w4=%h want %b %h %b %h",
                 i, e1, w1, e4, w4, exp_en1, exp_w1, exp_en4, exp_w4);
      end
    end
    read_ready = 1'b0;
    gs = 0;
  endtask

`ifdef AUDIO_FEEDER_GAIN_EN
  task automatic test_gain();
    int ls[2] = '{1000, 4000000};
    int ws[2] = '{8000, 8388607};
    int lat; bit bad; logic e1, e4; logic [W-1:0] w1, w4, want;
    gs = 3;
    for (int k = 0; k < 2; k++) begin
      pop_one(ls[k], ls[k], 1'b0, 1'b0, lat, bad, e1, e4, w1, w4);
      model_step(ls[k], ls[k], 1'b0);
      want = ws[k][W-1:0];
      checks++;
      if (e1 !== 1'b1 || w1 !== want) begin
        errors++;
        $display("FAIL gain%0d: got en=%b wave=%0d want en=1 wave=%0d", k, e1, w1, want);
      end
    end
    gs = 0;
  endtask
`endif

  initial begin
    reset = 1'b1;
    read_ready = 1'b0;
    freeze = 1'b0;
    left = '0;
    right = '0;
`ifdef AUDIO_FEEDER_GAIN_EN
    gain_shift = 3'd0;
`endif
    model_reset();
    @(negedge clk);
    test_reset();
    test_basic();
    test_signed_mix();
    test_decimation();
    test_freeze();
    test_async_reset();
`ifdef AUDIO_FEEDER_GAIN_EN
    test_gain();
`endif
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
